cpu_int_ctrl: RTL
=================

# cpu_int_ctrl

Parametrised interrupt and reset sequencer for the 6502 core. It synchronises N level-sensitive IRQ sources and one edge-triggered NMI, and holds the core in reset for a programmable count. At instruction boundaries it arbitrates RESET > NMI > IRQ and presents a single request, type and vector address to the core through a request/acknowledge handshake. It replaces the single raw IRQ/NMI pins at the core top level and adds per-source masking, NMI edge latching and IRQ→NMI upgrade.

## Interface
- N_IRQ, 4: number of IRQ sources, 1..8
- SYNC_STAGES, 2: synchroniser flops per async input, ≥1
- RES_CYCLES, 7: clk cycles core_rst is held after res deasserts, 1..255
- clk  in  1  system clock, all state on rising edge
- res  in  1  reset, asynchronous, active-low
- RDY  in  1  core ready; 0 freezes FSM and reset counter
- irq_n  in  N_IRQ  interrupt requests, active-low level, asynchronous
- nmi_n  in  1  non-maskable interrupt, falling-edge, asynchronous
- irq_mask  in  N_IRQ  per-source enable, 1 = enabled
- i_flag  in  1  core status I bit, 1 = IRQs inhibited
- sync  in  1  core opcode-fetch cycle (instruction boundary)
- int_ack  in  1  core has taken the vector, one-cycle pulse
- core_rst  out  1  core reset, active-high
- int_req  out  1  request pending to core
- int_type  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET
- int_vec  out  16  vector address: FFFC RESET, FFFA NMI, FFFE IRQ
- irq_pend  out  N_IRQ  synchronised, masked active sources

## Operation
- res low (async): state RST_HOLD, counter = RES_CYCLES, nmi_latch = 0, synchroniser flops = 1. Outputs: core_rst=1, int_req=0, int_type=00, int_vec=FFFC, irq_pend=0.
- RST_HOLD: counter decrements each cycle with RDY=1. At 0, go to RST_REQ.
- RST_REQ: core_rst=0, int_req=1, int_type=11, int_vec=FFFC. int_ack → IDLE.
- IDLE: int_req=0, int_type=00, int_vec holds its last value. On a cycle with sync=1 and RDY=1:
  - if nmi_latch → PEND with NMI / FFFA;
  - else if irq_any → PEND with IRQ / FFFE;
  - else stay in IDLE.
- PEND: int_req=1, type and vector frozen. Exception: if type=IRQ and nmi_latch=1 with no int_ack in the same cycle, upgrade to NMI/FFFA next cycle (hijack). int_ack → IDLE. If type was NMI, clear nmi_latch.
- irq_any = |(~irq_sync & irq_mask) & ~i_flag. irq_pend = ~irq_sync & irq_mask, independent of i_flag and state.
- IRQ withdrawal or mask change while in PEND does not cancel the request.
- NMI: falling edge of synchronised nmi_n sets nmi_latch. Further edges while latched merge into one service. An edge in the same cycle as the clearing ack leaves the latch set (set wins).
- int_ack outside PEND/RST_REQ is ignored. RDY=0 freezes state, counter and outputs. Synchronisers, edge detect and nmi_latch keep running.
- res asserted mid-sequence aborts any request immediately; state returns to RST_HOLD.

## Timing
- Async input sampled low at edge k → synchronised value valid after edge k+SYNC_STAGES−1.
- nmi_latch sets one cycle after that. irq_pend updates combinationally from synced values.
- Request latency: PEND is entered on the edge ending the qualifying sync&RDY cycle, so int_req is high the following cycle.
- Ack latency: int_req falls on the edge after the int_ack cycle. Back-to-back service is possible at the next sync.
- Reset: core_rst stays high for exactly RES_CYCLES RDY-qualified cycles after res rises. It falls on the same edge that raises int_req with type 11.
- No combinational path from inputs to int_req, int_type, int_vec or core_rst. All are registered.

## Test plan
- Reset: N_IRQ=4, RES_CYCLES=7, RDY=1. Release res → core_rst high for 7 cycles, then int_req=1, type=11, vec=FFFC. Ack → int_req=0 next cycle.
- IRQ mask/inhibit: irq_n=1110, irq_mask=0001, i_flag=0, pulse sync → irq_pend=0001, int_req=1 type 01 vec FFFE. Repeat with i_flag=1 → no request, irq_pend still 0001.
- NMI merge: two nmi_n falling edges 3 cycles apart, then sync → a single NMI request (FFFA). After ack, a further sync gives no request.
- Hijack: IRQ in PEND, no ack. NMI edge arrives → next cycle type 10 vec FFFA. Ack clears nmi_latch. The still-active IRQ is served at the next sync.
- RDY stall: RDY=0 during RST_HOLD for 5 cycles → core_rst is high for 7+5 cycles. RDY=0 with sync=1 → no PEND entry.
- Mid-operation reset: res low while in PEND → same cycle core_rst=1, int_req=0, int_type=00, nmi_latch=0.

Source files
------------

// File: rtl/cpu_int_ctrl.sv
// cpu_int_ctrl: interrupt and reset sequencer for the 6502 core.
// Synchronises N level IRQ sources and one falling-edge NMI, stretches reset
// for a programmable number of RDY-qualified cycles, and arbitrates
// RESET > NMI > IRQ at instruction boundaries through a req/ack handshake.
module cpu_int_ctrl #(
  parameter int unsigned N_IRQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RES_CYCLES  = 7
) (
  input  logic             clk,
  input  logic             res,
  input  logic             RDY,
  input  logic [N_IRQ-1:0] irq_n,
  input  logic             nmi_n,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             i_flag,
  input  logic             sync,
  input  logic             int_ack,
  output logic             core_rst,
  output logic             int_req,
  output logic [1:0]       int_type,
  output logic [15:0]      int_vec,
  output logic [N_IRQ-1:0] irq_pend
);

  localparam int unsigned CNT_W = 8;

  // Sequencer states
  localparam logic [1:0] RST_HOLD = 2'd0;
  localparam logic [1:0] RST_REQ  = 2'd1;
  localparam logic [1:0] IDLE     = 2'd2;
  localparam logic [1:0] PEND     = 2'd3;

  // Request type encodings presented to the core
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_IRQ  = 2'b01;
  localparam logic [1:0] TYPE_NMI  = 2'b10;
  localparam logic [1:0] TYPE_RES  = 2'b11;

  // Vector addresses
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // ---------------------------------------------------------------------------
  // Input synchronisers (reset to the inactive level 1)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] irq_ff;
  logic [SYNC_STAGES-1:0]            nmi_ff;
  logic [N_IRQ-1:0]                  irq_sync;
  logic                              nmi_sync;
  logic                              nmi_prev;
  logic                              nmi_fall;
  logic                              nmi_latch;
  logic                              nmi_latch_d;
  logic                              nmi_clr;
  logic                              irq_any;

  // Shift asynchronous IRQ/NMI levels through the synchroniser chains
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      irq_ff <= '1;
      nmi_ff <= '1;
    end else begin
      irq_ff[0] <= irq_n;
      nmi_ff[0] <= nmi_n;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        irq_ff[i] <= irq_ff[i-1];
        nmi_ff[i] <= nmi_ff[i-1];
      end
    end
  end

  assign irq_sync = irq_ff[SYNC_STAGES-1];
  assign nmi_sync = nmi_ff[SYNC_STAGES-1];

  // Masked active sources, visible regardless of I flag or sequencer state
  assign irq_pend = ~irq_sync & irq_mask;
  assign irq_any  = (|irq_pend) & ~i_flag;

  // Falling edge of the synchronised NMI level
  assign nmi_fall = nmi_prev & ~nmi_sync;

  // A new edge beats a simultaneous clear so no NMI is ever lost
  always_comb begin
    nmi_latch_d = nmi_latch;
    if (nmi_fall) begin
      nmi_latch_d = 1'b1;
    end else if (nmi_clr) begin
      nmi_latch_d = 1'b0;
    end
  end

  // NMI edge detector history and pending-NMI latch; run even while RDY=0
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      nmi_prev  <= 1'b1;
      nmi_latch <= 1'b0;
    end else begin
      nmi_prev  <= nmi_sync;
      nmi_latch <= nmi_latch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             core_rst_d;
  logic             int_req_d;
  logic [1:0]       int_type_d;
  logic [15:0]      int_vec_d;

  // State, counter and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= RST_HOLD;
      cnt      <= CNT_W'(RES_CYCLES);
      core_rst <= 1'b1;
      int_req  <= 1'b0;
      int_type <= TYPE_NONE;
      int_vec  <= VEC_RES;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      core_rst <= core_rst_d;
      int_req  <= int_req_d;
      int_type <= int_type_d;
      int_vec  <= int_vec_d;
    end
  end

  // Next-state and next-output decode; RDY=0 holds everything frozen
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    core_rst_d = core_rst;
    int_req_d  = int_req;
    int_type_d = int_type;
    int_vec_d  = int_vec;
    nmi_clr    = 1'b0;

    if (RDY) begin
      case (state)
        RST_HOLD: begin
          // Leave on the edge that consumes the last count so core_rst spans
          // exactly RES_CYCLES qualified cycles
          if (cnt <= CNT_W'(1)) begin
            state_d    = RST_REQ;
            cnt_d      = '0;
            core_rst_d = 1'b0;
            int_req_d  = 1'b1;
            int_type_d = TYPE_RES;
            int_vec_d  = VEC_RES;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end

        RST_REQ: begin
          if (int_ack) begin
            state_d    = IDLE;
            int_req_d  = 1'b0;
            int_type_d = TYPE_NONE;
          end
        end

        IDLE: begin
          // Arbitrate only at instruction boundaries; vector holds otherwise
          if (sync) begin
            if (nmi_latch) begin
              state_d    = PEND;
              int_req_d  = 1'b1;
              int_type_d = TYPE_NMI;
              int_vec_d  = VEC_NMI;
            end else if (irq_any) begin
              state_d    = PEND;
              int_req_d  = 1'b1;
              int_type_d = TYPE_IRQ;
              int_vec_d  = VEC_IRQ;
            end
          end
        end

        PEND: begin
          if (int_ack) begin
            state_d    = IDLE;
            int_req_d  = 1'b0;
            int_type_d = TYPE_NONE;
            nmi_clr    = (int_type == TYPE_NMI);
          end else if ((int_type == TYPE_IRQ) && nmi_latch) begin
            // Unacknowledged IRQ is hijacked by a newly pending NMI
            int_type_d = TYPE_NMI;
            int_vec_d  = VEC_NMI;
          end
        end

        default: begin
          state_d = RST_HOLD;
        end
      endcase
    end
  end

endmodule
